io_timer_bank: RTL and testbench

//  Parametrised successor to the single free-running ticks counter on the J1 I/O bus.

---
 rtl/io_timer_bank_pkg.sv | 24 ++
 rtl/io_timer_bank_channel.sv | 125 ++++++++++++
 rtl/io_timer_bank.sv | 88 ++++++++
 tb/tb_io_timer_bank.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_timer_bank_pkg.sv
// Shared register map and CTRL/STATUS bit positions for the J1 I/O timer bank.
// Imported by the channel and the bank top.
package io_timer_bank_pkg;

   localparam int DATA_W = 16;
   localparam int PRESC_W = 8;

   typedef enum logic [1:0] {
      REG_COUNT   = 2'd0,
      REG_COMPARE = 2'd1,
      REG_CTRL    = 2'd2,
      REG_STATUS  = 2'd3
   } regOffset_e;

   localparam int CTRL_EN        = 0;
   localparam int CTRL_ONESHOT   = 1;
   localparam int CTRL_MIE       = 2;
   localparam int CTRL_OIE       = 3;
   localparam int CTRL_PRESC_LSB = 8;

   localparam int STATUS_MATCH = 0;
   localparam int STATUS_OVF   = 1;

endpackage

// File: rtl/io_timer_bank_channel.sv
// One timer channel: prescaler, up-counter, compare, periodic/one-shot mode and
// sticky MATCH/OVF flags with their interrupt enables.
module io_timer_channel
   import io_timer_bank_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic              clk,
   input  logic              resetq,
   input  logic              wrCount_i,
   input  logic              wrCompare_i,
   input  logic              wrCtrl_i,
   input  logic              wrStatus_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] countRd_o,
   output logic [DATA_W-1:0] compareRd_o,
   output logic [DATA_W-1:0] ctrlRd_o,
   output logic [DATA_W-1:0] statusRd_o,
   output logic              irqReq_o
);

   logic [WIDTH-1:0]   count_q, count_d;
   logic [WIDTH-1:0]   compare_q, compare_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [PRESC_W-1:0] pc_q, pc_d;
   logic               en_q, en_d;
   logic               oneShot_q, oneShot_d;
   logic               mie_q, mie_d;
   logic               oie_q, oie_d;
   logic               match_q, match_d;
   logic               ovf_q, ovf_d;
   logic               tick;
   logic               setMatch;
   logic               setOvf;

   always_comb begin
      count_d   = count_q;
      compare_d = compare_q;
      presc_d   = presc_q;
      pc_d      = pc_q;
      en_d      = en_q;
      oneShot_d = oneShot_q;
      mie_d     = mie_q;
      oie_d     = oie_q;
      setMatch  = 1'b0;
      setOvf    = 1'b0;
      tick      = en_q && (pc_q == presc_q);

      if (en_q) begin
         pc_d = tick ? '0 : pc_q + PRESC_W'(1);
      end

      // A match at the maximum count takes priority over overflow.
      if (tick) begin
         if (count_q == compare_q) begin
            setMatch = 1'b1;
            if (oneShot_q) begin
               en_d = 1'b0;
            end else begin
               count_d = '0;
            end
         end else if (count_q == {WIDTH{1'b1}}) begin
            count_d = '0;
            setOvf  = 1'b1;
         end else begin
            count_d = count_q + WIDTH'(1);
         end
      end

      if (wrCount_i) begin
         count_d = wdata_i[WIDTH-1:0];
         pc_d    = '0;
      end
      if (wrCompare_i) begin
         compare_d = wdata_i[WIDTH-1:0];
      end
      if (wrCtrl_i) begin
         if (wdata_i[CTRL_EN] && !en_q) begin
            pc_d = '0;
         end
         en_d      = wdata_i[CTRL_EN];
         oneShot_d = wdata_i[CTRL_ONESHOT];
         mie_d     = wdata_i[CTRL_MIE];
         oie_d     = wdata_i[CTRL_OIE];
         presc_d   = wdata_i[CTRL_PRESC_LSB +: PRESC_W];
      end

      // A flag being set in the same cycle survives a software clear.
      match_d = (match_q && !(wrStatus_i && wdata_i[STATUS_MATCH])) || setMatch;
      ovf_d   = (ovf_q && !(wrStatus_i && wdata_i[STATUS_OVF])) || setOvf;
   end

   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         count_q   <= '0;
         compare_q <= '0;
         presc_q   <= '0;
         pc_q      <= '0;
         en_q      <= 1'b0;
         oneShot_q <= 1'b0;
         mie_q     <= 1'b0;
         oie_q     <= 1'b0;
         match_q   <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         count_q   <= count_d;
         compare_q <= compare_d;
         presc_q   <= presc_d;
         pc_q      <= pc_d;
         en_q      <= en_d;
         oneShot_q <= oneShot_d;
         mie_q     <= mie_d;
         oie_q     <= oie_d;
         match_q   <= match_d;
         ovf_q     <= ovf_d;
      end
   end

   assign countRd_o   = DATA_W'(count_q);
   assign compareRd_o = DATA_W'(compare_q);
   assign ctrlRd_o    = {presc_q, 4'b0000, oie_q, mie_q, oneShot_q, en_q};
   assign statusRd_o  = {14'b0, ovf_q, match_q};
   assign irqReq_o    = (match_q && mie_q) || (ovf_q && oie_q);

endmodule

// File: rtl/io_timer_bank.sv
// Bank of independent timer channels on the J1 io bus: address decode,
// zero-latency read mux and a registered, level-sensitive interrupt request.
module io_timer_bank
   import io_timer_bank_pkg::*;
#(
   parameter  int CHANNELS = 4,
   parameter  int WIDTH    = 16,
   localparam int AW       = $clog2(CHANNELS) + 2
) (
   input  logic              clk,
   input  logic              resetq,
   input  logic              sel,
   input  logic              io_rd,
   input  logic              io_wr,
   input  logic [AW-1:0]     reg_addr,
   input  logic [DATA_W-1:0] io_dout,
   output logic [DATA_W-1:0] rdata,
   output logic              irq
);

   logic [DATA_W-1:0] countRd   [CHANNELS];
   logic [DATA_W-1:0] compareRd [CHANNELS];
   logic [DATA_W-1:0] ctrlRd    [CHANNELS];
   logic [DATA_W-1:0] statusRd  [CHANNELS];
   logic [CHANNELS-1:0] irqReq;
   regOffset_e regOff;
   int         chanIdx;
   logic       irq_q;
   logic       unusedRd;

   // Reads are side-effect free, so the read strobe carries no information.
   assign unusedRd = io_rd;

   always_comb begin
      regOff  = regOffset_e'(reg_addr[1:0]);
      chanIdx = int'(reg_addr >> 2);
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : gChan
      logic wrHit;
      assign wrHit = sel && io_wr && (chanIdx == g);

      io_timer_channel #(
         .WIDTH(WIDTH)
      ) uChannel (
         .clk        (clk),
         .resetq     (resetq),
         .wrCount_i  (wrHit && (regOff == REG_COUNT)),
         .wrCompare_i(wrHit && (regOff == REG_COMPARE)),
         .wrCtrl_i   (wrHit && (regOff == REG_CTRL)),
         .wrStatus_i (wrHit && (regOff == REG_STATUS)),
         .wdata_i    (io_dout),
         .countRd_o  (countRd[g]),
         .compareRd_o(compareRd[g]),
         .ctrlRd_o   (ctrlRd[g]),
         .statusRd_o (statusRd[g]),
         .irqReq_o   (irqReq[g])
      );
   end

   // Addresses past the last channel read as zero.
   always_comb begin
      rdata = '0;
      if (sel) begin
         for (int c = 0; c < CHANNELS; c++) begin
            if (chanIdx == c) begin
               case (regOff)
                  REG_COUNT:   rdata = countRd[c];
                  REG_COMPARE: rdata = compareRd[c];
                  REG_CTRL:    rdata = ctrlRd[c];
                  REG_STATUS:  rdata = statusRd[c];
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= |irqReq;
      end
   end

   assign irq = irq_q;

endmodule

// File: tb/tb_io_timer_bank.sv
// Bench for io_timer_bank (8-channel build): directed scenarios plus random
// register traffic checked against a behavioural model of every channel.
module tb_io_timer_bank;

   localparam int CH = 8;
   localparam int AW = 5;

   logic          clk;
   logic          resetq;
   logic          sel;
   logic          io_rd;
   logic          io_wr;
   logic [AW-1:0] reg_addr;
   logic [15:0]   io_dout;
   logic [15:0]   rdata;
   logic          irq;

   int checks = 0;
   int errors = 0;

   // Behavioural model state.
   logic [15:0] mCount   [CH];
   logic [15:0] mCompare [CH];
   logic [7:0]  mPresc   [CH];
   logic [7:0]  mPc      [CH];
   bit          mEn      [CH];
   bit          mOne     [CH];
   bit          mMie     [CH];
   bit          mOie     [CH];
   bit          mMatch   [CH];
   bit          mOvf     [CH];
   bit          mIrq;

   io_timer_bank #(.CHANNELS(CH), .WIDTH(16)) dut (
      .clk     (clk),
      .resetq  (resetq),
      .sel     (sel),
      .io_rd   (io_rd),
      .io_wr   (io_wr),
      .reg_addr(reg_addr),
      .io_dout (io_dout),
      .rdata   (rdata),
      .irq     (irq)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   initial begin
      #4000000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic modelReset();
      for (int c = 0; c < CH; c++) begin
         mCount[c] = '0; mCompare[c] = '0; mPresc[c] = '0; mPc[c] = '0;
         mEn[c] = 0; mOne[c] = 0; mMie[c] = 0; mOie[c] = 0;
         mMatch[c] = 0; mOvf[c] = 0;
      end
      mIrq = 0;
   endtask

   // One clock edge of the whole bank, with an optional register write.
   task automatic modelStep(input bit wr, input int wch, input int wrg, input logic [15:0] d);
      bit newIrq, tick, setM, setO, oldEn;
      newIrq = 0;
      for (int c = 0; c < CH; c++) begin
         if ((mMatch[c] && mMie[c]) || (mOvf[c] && mOie[c])) newIrq = 1;
      end
      for (int c = 0; c < CH; c++) begin
         oldEn = mEn[c];
         tick  = mEn[c] && (mPc[c] == mPresc[c]);
         setM  = 0;
         setO  = 0;
         if (mEn[c]) mPc[c] = tick ? 8'd0 : mPc[c] + 8'd1;
         if (tick) begin
            if (mCount[c] == mCompare[c]) begin
               setM = 1;
               if (mOne[c]) mEn[c] = 0;
               else mCount[c] = 0;
            end else if (mCount[c] == 16'hFFFF) begin
               mCount[c] = 0;
               setO = 1;
            end else begin
               mCount[c] = mCount[c] + 16'd1;
            end
         end
         if (wr && wch == c) begin
            case (wrg)
               0: begin mCount[c] = d; mPc[c] = 0; end
               1: mCompare[c] = d;
               2: begin
                  if (d[0] && !oldEn) mPc[c] = 0;
                  mEn[c] = d[0]; mOne[c] = d[1]; mMie[c] = d[2]; mOie[c] = d[3];
                  mPresc[c] = d[15:8];
               end
               default: begin
                  if (d[0]) mMatch[c] = 0;
                  if (d[1]) mOvf[c] = 0;
               end
            endcase
         end
         if (setM) mMatch[c] = 1;
         if (setO) mOvf[c] = 1;
      end
      mIrq = newIrq;
   endtask

   function automatic logic [15:0] mRead(input int ch, input int rg);
      case (rg)
         0: return mCount[ch];
         1: return mCompare[ch];
         2: return {mPresc[ch], 4'b0000, mOie[ch], mMie[ch], mOne[ch], mEn[ch]};
         default: return {14'b0, mOvf[ch], mMatch[ch]};
      endcase
   endfunction

   task automatic applyStimulus(input int ch, input int rg, input logic [15:0] d);
      sel = 1; io_wr = 1; io_dout = d;
      reg_addr = AW'(ch * 4 + rg);
      @(posedge clk);
      modelStep(1, ch, rg, d);
      #1;
      io_wr = 0; sel = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         modelStep(0, 0, 0, 16'h0);
         #1;
      end
   endtask

   task automatic readReg(input int ch, input int rg, output logic [15:0] v);
      sel = 1; io_rd = 1;
      reg_addr = AW'(ch * 4 + rg);
      #1;
      v = rdata;
      sel = 0; io_rd = 0;
   endtask

   task automatic test_reset();
      logic [15:0] v;
      for (int c = 0; c < CH; c++) begin
         for (int r = 0; r < 4; r++) begin
            readReg(c, r, v);
            checks++;
            if (v !== 16'h0) begin
               errors++;
               $display("[TB] FAIL reset_reg ch%0d r%0d: got %h expected 0000", c, r, v);
            end
         end
      end
      checks++;
      if (irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq: got %b expected 0", irq); end
      applyStimulus(0, 1, 16'd100);
      applyStimulus(0, 2, 16'h0001);
      idle(10);
      readReg(0, 0, v);
      checks++;
      if (v !== 16'd10) begin errors++; $display("[TB] FAIL free_count: got %0d expected 10", v); end
      applyStimulus(0, 2, 16'h0000);
      applyStimulus(0, 0, 16'h0000);
   endtask

   task automatic test_periodic();
      logic [15:0] v;
      logic [15:0] seq [5] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd0};
      applyStimulus(0, 1, 16'd4);
      applyStimulus(0, 2, 16'h0005);
      for (int i = 0; i < 5; i++) begin
         idle(1);
         readReg(0, 0, v);
         checks++;
         if (v !== seq[i]) begin errors++; $display("[TB] FAIL periodic_count step%0d: got %h expected %h", i, v, seq[i]); end
      end
      readReg(0, 3, v);
      checks++;
      if (v !== 16'h0001) begin errors++; $display("[TB] FAIL periodic_match: got %h expected 0001", v); end
      checks++;
      if (irq !== 1'b0) begin errors++; $display("[TB] FAIL periodic_irq_early: got %b expected 0", irq); end
      idle(1);
      checks++;
      if (irq !== 1'b1) begin errors++; $display("[TB] FAIL periodic_irq: got %b expected 1", irq); end
      applyStimulus(0, 2, 16'h0004);
      applyStimulus(0, 3, 16'h0001);
      readReg(0, 3, v);
      checks++;
      if (v !== 16'h0000) begin errors++; $display("[TB] FAIL w1c_status: got %h expected 0000", v); end
      checks++;
      if (irq !== 1'b1) begin errors++; $display("[TB] FAIL w1c_irq_hold: got %b expected 1", irq); end
      idle(1);
      checks++;
      if (irq !== 1'b0) begin errors++; $display("[TB] FAIL w1c_irq_drop: got %b expected 0", irq); end
   endtask

   task automatic test_oneshot();
      logic [15:0] v;
      applyStimulus(1, 1, 16'd2);
      applyStimulus(1, 2, 16'h0303);
      idle(11);
      readReg(1, 3, v);
      checks++;
      if (v !== 16'h0000) begin errors++; $display("[TB] FAIL oneshot_early: got %h expected 0000", v); end
      idle(1);
      readReg(1, 3, v);
      checks++;
      if (v !== 16'h0001) begin errors++; $display("[TB] FAIL oneshot_match: got %h expected 0001", v); end
      readReg(1, 2, v);
      checks++;
      if (v !== 16'h0302) begin errors++; $display("[TB] FAIL oneshot_en_off: got %h expected 0302", v); end
      idle(8);
      readReg(1, 0, v);
      checks++;
      if (v !== 16'd2) begin errors++; $display("[TB] FAIL oneshot_park: got %h expected 0002", v); end
      applyStimulus(1, 3, 16'h0001);
      applyStimulus(1, 2, 16'h0303);
      idle(3);
      readReg(1, 3, v);
      checks++;
      if (v !== 16'h0000) begin errors++; $display("[TB] FAIL rearm_early: got %h expected 0000", v); end
      idle(1);
      readReg(1, 3, v);
      checks++;
      if (v !== 16'h0001) begin errors++; $display("[TB] FAIL rearm_match: got %h expected 0001", v); end
      applyStimulus(1, 3, 16'h0001);
   endtask

   task automatic test_overflow();
      logic [15:0] v;
      applyStimulus(2, 1, 16'h0010);
      applyStimulus(2, 0, 16'hFFFE);
      applyStimulus(2, 2, 16'h0009);
      idle(2);
      readReg(2, 0, v);
      checks++;
      if (v !== 16'h0000) begin errors++; $display("[TB] FAIL ovf_wrap: got %h expected 0000", v); end
      readReg(2, 3, v);
      checks++;
      if (v !== 16'h0002) begin errors++; $display("[TB] FAIL ovf_flag: got %h expected 0002", v); end
      idle(1);
      checks++;
      if (irq !== 1'b1) begin errors++; $display("[TB] FAIL ovf_irq: got %b expected 1", irq); end
      applyStimulus(2, 2, 16'h0008);
      applyStimulus(2, 3, 16'h0003);
      applyStimulus(2, 1, 16'hFFFF);
      applyStimulus(2, 0, 16'hFFFE);
      applyStimulus(2, 2, 16'h0009);
      idle(2);
      readReg(2, 3, v);
      checks++;
      if (v !== 16'h0001) begin errors++; $display("[TB] FAIL max_match_priority: got %h expected 0001", v); end
      applyStimulus(2, 2, 16'h0000);
      applyStimulus(2, 3, 16'h0003);
      idle(1);
      checks++;
      if (irq !== 1'b0) begin errors++; $display("[TB] FAIL ovf_irq_clear: got %b expected 0", irq); end
   endtask

   task automatic test_collisions();
      logic [15:0] v;
      applyStimulus(3, 1, 16'h1000);
      applyStimulus(3, 2, 16'h0101);
      idle(1);
      applyStimulus(3, 0, 16'h0123);
      idle(1);
      readReg(3, 0, v);
      checks++;
      if (v !== 16'h0123) begin errors++; $display("[TB] FAIL count_write_wins: got %h expected 0123", v); end
      idle(1);
      readReg(3, 0, v);
      checks++;
      if (v !== 16'h0124) begin errors++; $display("[TB] FAIL count_after_write: got %h expected 0124", v); end
      applyStimulus(3, 0, 16'h0200);
      idle(1);
      readReg(3, 0, v);
      checks++;
      if (v !== 16'h0200) begin errors++; $display("[TB] FAIL count_write_pc_clear: got %h expected 0200", v); end
      applyStimulus(3, 2, 16'h0000);
      applyStimulus(4, 1, 16'd3);
      applyStimulus(4, 2, 16'h0001);
      idle(3);
      applyStimulus(4, 3, 16'h0001);
      readReg(4, 3, v);
      checks++;
      if (v !== 16'h0001) begin errors++; $display("[TB] FAIL set_beats_clear: got %h expected 0001", v); end
      applyStimulus(4, 2, 16'h0000);
      applyStimulus(4, 3, 16'h0003);
   endtask

   task automatic test_irq_select();
      logic [15:0] v;
      applyStimulus(0, 0, 16'h0000);
      applyStimulus(0, 1, 16'd1);
      applyStimulus(0, 2, 16'h0001);
      idle(3);
      readReg(0, 3, v);
      checks++;
      if (v !== 16'h0001) begin errors++; $display("[TB] FAIL ch0_match: got %h expected 0001", v); end
      checks++;
      if (irq !== 1'b0) begin errors++; $display("[TB] FAIL ch0_masked_irq: got %b expected 0", irq); end
      applyStimulus(7, 1, 16'd1);
      applyStimulus(7, 2, 16'h0005);
      idle(2);
      checks++;
      if (irq !== 1'b0) begin errors++; $display("[TB] FAIL ch7_irq_early: got %b expected 0", irq); end
      idle(1);
      checks++;
      if (irq !== 1'b1) begin errors++; $display("[TB] FAIL ch7_irq: got %b expected 1", irq); end
      applyStimulus(7, 2, 16'h0004);
      applyStimulus(7, 3, 16'h0003);
      checks++;
      if (irq !== 1'b1) begin errors++; $display("[TB] FAIL ch7_irq_hold: got %b expected 1", irq); end
      idle(1);
      checks++;
      if (irq !== 1'b0) begin errors++; $display("[TB] FAIL ch7_irq_drop: got %b expected 0", irq); end
      #2;
      resetq = 0;
      modelReset();
      #1;
      checks++;
      if (irq !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_irq: got %b expected 0", irq); end
      for (int r = 0; r < 4; r++) begin
         readReg(0, r, v);
         checks++;
         if (v !== 16'h0) begin errors++; $display("[TB] FAIL async_reset ch0 r%0d: got %h expected 0000", r, v); end
      end
      readReg(7, 2, v);
      checks++;
      if (v !== 16'h0) begin errors++; $display("[TB] FAIL async_reset ch7 ctrl: got %h expected 0000", v); end
      resetq = 1;
      idle(1);
   endtask

   task automatic checkOutput(input int iter);
      logic [15:0] v, e;
      int rch;
      checks++;
      if (irq !== mIrq) begin errors++; $display("[TB] FAIL rand_irq it%0d: got %b expected %b", iter, irq, mIrq); end
      rch = $urandom_range(0, CH - 1);
      for (int r = 0; r < 4; r++) begin
         readReg(rch, r, v);
         e = mRead(rch, r);
         checks++;
         if (v !== e) begin errors++; $display("[TB] FAIL rand_reg it%0d ch%0d r%0d: got %h expected %h", iter, rch, r, v, e); end
      end
   endtask

   task automatic test_random();
      logic [15:0] d;
      int ch, rg;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            idle(1);
         end else begin
            ch = $urandom_range(0, CH - 1);
            rg = $urandom_range(0, 3);
            case (rg)
               0: d = ($urandom_range(0, 1) == 1) ? 16'(16'hFFF0 + $urandom_range(0, 15))
                                                  : 16'($urandom_range(0, 20));
               1: d = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(0, 20));
               2: d = {8'($urandom_range(0, 3)), 8'($urandom_range(0, 255))};
               default: d = 16'($urandom_range(0, 3));
            endcase
            applyStimulus(ch, rg, d);
         end
         checkOutput(i);
      end
   endtask

   initial begin
      resetq = 0; sel = 0; io_rd = 0; io_wr = 0; reg_addr = '0; io_dout = '0;
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      resetq = 1;
      test_reset();
      test_periodic();
      test_oneshot();
      test_overflow();
      test_collisions();
      test_irq_select();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
